// File: rtl/mrelbp_frame_seq_if.sv
// Pixel-buffer read port and pixel stream bundle between the frame sequencer
// (master) and the buffer/datapath side (slave).
interface mrelbp_frame_seq_if #(
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 8
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [PIX_W-1:0]  mem_rd_data;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_eof;
    logic              pix_ready;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/mrelbp_frame_seq.sv
// MRELBP frame sequencer: validates geometry, reads the frame linearly from the
// pixel buffer and streams it to the datapath, then waits for done or timeout.
module mrelbp_frame_seq #(
    parameter int ADDR_W  = 16,
    parameter int PIX_W   = 8,
    parameter int TIMEOUT = 4096,
    parameter int RST_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        control_reg_i,
    input  logic [31:0]        config_reg_i,
    mrelbp_frame_seq_if.master bus,
    input  logic               dp_done_i,
    output logic               dp_rst_o,
    output logic [31:0]        status_o,
    output logic               irq_o
);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RC_W  = $clog2(RST_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_STREAM, S_WAIT_DONE, S_DONE, S_ERR
    } state_t;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic             eof;
        logic [PIX_W-1:0] data;
    } beat_t;

    state_t            state_q, state_d;
    logic [1:0]        ctrl_q;
    logic [11:0]       w_q, h_q, col_q, row_q;
    logic [ADDR_W-1:0] addr_q;
    logic              left_q;
    logic              inflight_q;
    logic [2:0]        meta_q;
    beat_t             fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [RC_W-1:0]   rst_cnt_q;
    logic              done_q, cfg_err_q, tmo_err_q, ign_q;

    logic        start_ev, srst_ev, pop, issue, cfg_bad, tmo_hit;
    logic        is_sof, is_eol, is_eof;
    logic [2:0]  occ;
    logic [31:0] area;
    beat_t       head;
    logic        unused_bits;

    assign unused_bits = ^{control_reg_i[31:2], config_reg_i[31:24]};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        start_ev = control_reg_i[0] & ~ctrl_q[0];
        srst_ev  = control_reg_i[1] & ~ctrl_q[1];
        head     = fifo_q[rd_ptr_q];
        pop      = (cnt_q != 2'd0) & bus.pix_ready & ~srst_ev;
        occ      = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
        issue    = (state_q == S_STREAM) & left_q & ~srst_ev & (occ < 3'd2);
        is_sof   = (col_q == 12'd0) & (row_q == 12'd0);
        is_eol   = (col_q == w_q - 12'd1);
        is_eof   = is_eol & (row_q == h_q - 12'd1);
        area     = 32'(w_q) * 32'(h_q);
        cfg_bad  = (w_q == 12'd0) | (h_q == 12'd0) | ({32'd0, area} > (64'd1 << ADDR_W));
        tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 1));

        unique case (state_q)
            S_IDLE:      if (start_ev) state_d = S_CHECK;
            S_CHECK:     state_d = cfg_bad ? S_ERR : S_STREAM;
            S_STREAM:    if (pop && head.eof) state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (dp_done_i)    state_d = S_DONE;
                else if (tmo_hit) state_d = S_ERR;
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
        if (srst_ev) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            left_q     <= 1'b0;
            inflight_q <= 1'b0;
            meta_q     <= '0;
            // NOTE: the two FIFO entries are reset too; it is cheap and keeps the head defined.
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            rst_cnt_q  <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            ign_q      <= 1'b0;
        end else begin
            ctrl_q <= control_reg_i[1:0];
            if (srst_ev) begin
                // Abort: drop buffered and in-flight pixels, pulse the datapath reset.
                left_q     <= 1'b0;
                inflight_q <= 1'b0;
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
                cnt_q      <= '0;
                tmo_q      <= '0;
                rst_cnt_q  <= RC_W'(RST_CYC);
                done_q     <= 1'b0;
                cfg_err_q  <= 1'b0;
                tmo_err_q  <= 1'b0;
            end else begin
                if (rst_cnt_q != '0) rst_cnt_q <= rst_cnt_q - RC_W'(1);

                if (start_ev && state_q == S_IDLE) begin
                    done_q    <= 1'b0;
                    cfg_err_q <= 1'b0;
                    tmo_err_q <= 1'b0;
                    ign_q     <= 1'b0;
                    w_q       <= config_reg_i[11:0];
                    h_q       <= config_reg_i[23:12];
                    addr_q    <= '0;
                    col_q     <= '0;
                    row_q     <= '0;
                    left_q    <= 1'b1;
                end else if (start_ev) begin
                    ign_q <= 1'b1;
                end

                inflight_q <= issue;
                if (issue) begin
                    meta_q <= {is_sof, is_eol, is_eof};
                    addr_q <= addr_q + ADDR_W'(1);
                    if (is_eol) begin
                        col_q <= '0;
                        row_q <= row_q + 12'd1;
                    end else begin
                        col_q <= col_q + 12'd1;
                    end
                    if (is_eof) left_q <= 1'b0;
                end

                if (inflight_q) begin
                    fifo_q[wr_ptr_q] <= {meta_q, bus.mem_rd_data};
                    wr_ptr_q         <= ~wr_ptr_q;
                end
                if (pop) rd_ptr_q <= ~rd_ptr_q;
                cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};

                tmo_q <= (state_q == S_WAIT_DONE) ? tmo_q + TMO_W'(1) : '0;
                if (state_q == S_CHECK && cfg_bad) cfg_err_q <= 1'b1;
                if (state_q == S_WAIT_DONE) begin
                    if (dp_done_i)    done_q    <= 1'b1;
                    else if (tmo_hit) tmo_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = addr_q;
    assign bus.pix_valid   = (cnt_q != 2'd0) & ~srst_ev;
    assign bus.pix_data    = head.data;
    assign bus.pix_sof     = head.sof;
    assign bus.pix_eol     = head.eol;
    assign bus.pix_eof     = head.eof;

    assign dp_rst_o = (rst_cnt_q != '0);
    assign status_o = {27'd0, ign_q, tmo_err_q, cfg_err_q, done_q, state_q != S_IDLE};
    assign irq_o    = ((state_q == S_DONE) | (state_q == S_ERR)) & ~srst_ev;
endmodule

// File: tb/tb_mrelbp_frame_seq.sv
// Directed bench for mrelbp_frame_seq: buffer returns its address as data,
// a negedge monitor records beats, reads, irq pulses and soft-reset cycles.
module tb_mrelbp_frame_seq;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] control_reg;
    logic [31:0] config_reg;
    logic        dp_done;
    logic        dp_rst;
    logic [31:0] status;
    logic        irq;
    logic        toggle_en = 1'b0;

    mrelbp_frame_seq_if #(.ADDR_W(16), .PIX_W(8)) bus ();

    mrelbp_frame_seq #(.ADDR_W(16), .PIX_W(8), .TIMEOUT(TMO), .RST_CYC(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .control_reg_i (control_reg),
        .config_reg_i  (config_reg),
        .bus           (bus),
        .dp_done_i     (dp_done),
        .dp_rst_o      (dp_rst),
        .status_o      (status),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_rd_addr[7:0];

    always @(posedge clk) begin
        #1;
        if (toggle_en) bus.pix_ready = ~bus.pix_ready;
    end

    int          checks = 0;
    int          errors = 0;
    logic [10:0] beat_q [$];
    int          rd_q [$];
    int          cyc_q [$];
    int          cyc = 0;
    int          eof_cnt, irq_cnt, rst_cycles, issued, max_out, unstable;
    logic        prev_stall;
    logic [10:0] prev_head;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pix_valid && bus.pix_ready) begin
                beat_q.push_back({bus.pix_sof, bus.pix_eol, bus.pix_eof, bus.pix_data});
                cyc_q.push_back(cyc);
                if (bus.pix_eof) eof_cnt++;
            end
            if (bus.mem_rd_en) begin
                rd_q.push_back(int'(bus.mem_rd_addr));
                issued++;
            end
            if (issued - beat_q.size() > max_out) max_out = issued - beat_q.size();
            if (prev_stall && bus.pix_valid &&
                {bus.pix_sof, bus.pix_eol, bus.pix_eof, bus.pix_data} != prev_head) unstable++;
            prev_stall = bus.pix_valid & ~bus.pix_ready;
            prev_head  = {bus.pix_sof, bus.pix_eol, bus.pix_eof, bus.pix_data};
            if (irq) irq_cnt++;
            if (dp_rst) rst_cycles++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        beat_q.delete();
        rd_q.delete();
        cyc_q.delete();
        eof_cnt    = 0;
        irq_cnt    = 0;
        rst_cycles = 0;
        issued     = 0;
        max_out    = 0;
        unstable   = 0;
        prev_stall = 1'b0;
    endtask

    task automatic pulse_ctrl(input int b);
        @(posedge clk); #1 control_reg = 32'd1 << b;
        @(posedge clk); #1 control_reg = 32'd0;
    endtask

    task automatic start_frame(input int w, input int h);
        clear_mon();
        config_reg = {8'd0, 12'(h), 12'(w)};
        pulse_ctrl(0);
    endtask

    task automatic wait_eof(input int budget);
        for (int i = 0; i < budget && eof_cnt == 0; i++) begin
            @(negedge clk); #1;
        end
        check("eof_seen", 32'(eof_cnt), 32'd1);
    endtask

    task automatic check_frame(input int w, input int h);
        logic [10:0] e;
        check("beat_count", 32'(beat_q.size()), 32'(w * h));
        for (int i = 0; i < beat_q.size() && i < w * h; i++) begin
            e = {i == 0, (i % w) == w - 1, i == w * h - 1, 8'(i)};
            check($sformatf("beat%0d", i), 32'(beat_q[i]), 32'(e));
        end
        check("read_count", 32'(rd_q.size()), 32'(w * h));
        for (int i = 0; i < rd_q.size() && i < w * h; i++)
            check($sformatf("rd_addr%0d", i), 32'(rd_q[i]), 32'(i));
    endtask

    task automatic finish_done();
        repeat (5) @(posedge clk);
        #1 dp_done = 1'b1;
        @(posedge clk); #1 dp_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        control_reg   = '0;
        config_reg    = '0;
        dp_done       = 1'b0;
        bus.pix_ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_status", status, 32'h0);
        check("rst_outs", {28'd0, bus.pix_valid, bus.mem_rd_en, irq, dp_rst}, 32'h0);
        rst_n = 1'b1;

        // Basic 4x2 frame at full rate, then done.
        start_frame(4, 2);
        wait_eof(100);
        check_frame(4, 2);
        if (cyc_q.size() == 8) check("full_rate", 32'(cyc_q[7] - cyc_q[0]), 32'd7);
        finish_done();
        check("t1_irq", 32'(irq_cnt), 32'd1);
        check("t1_status", status, 32'h2);

        // 3x3 frame with ready toggling every cycle.
        toggle_en = 1'b1;
        start_frame(3, 3);
        wait_eof(200);
        toggle_en = 1'b0;
        #2 bus.pix_ready = 1'b1;
        check_frame(3, 3);
        check("t2_stable", 32'(unstable), 32'd0);
        check("t2_outstanding", 32'(max_out <= 2), 32'd1);
        finish_done();
        check("t2_status", status, 32'h2);

        // Illegal geometries never stream.
        start_frame(0, 5);
        repeat (8) @(posedge clk);
        #1;
        check("w0_reads", 32'(rd_q.size()), 32'd0);
        check("w0_status", status, 32'h4);
        check("w0_irq", 32'(irq_cnt), 32'd1);
        start_frame(256, 257);
        repeat (8) @(posedge clk);
        #1;
        check("big_reads", 32'(rd_q.size()), 32'd0);
        check("big_status", status, 32'h4);
        check("big_irq", 32'(irq_cnt), 32'd1);

        // Timeout with dp_done never asserted.
        start_frame(2, 1);
        wait_eof(100);
        check_frame(2, 1);
        n = 0;
        for (int i = 0; i < 100 && !irq; i++) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_latency", 32'(n), 32'(TMO + 1));
        repeat (3) @(posedge clk);
        #1;
        check("tmo_status", status, 32'h8);
        check("tmo_irq", 32'(irq_cnt), 32'd1);

        // Soft reset after the fifth beat of an 8-beat frame.
        start_frame(4, 2);
        for (int i = 0; i < 100 && beat_q.size() < 5; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1 control_reg = 32'h2;
        @(posedge clk); #1 control_reg = 32'h0;
        repeat (6) @(posedge clk);
        #1;
        check("srst_beats", 32'(beat_q.size()), 32'd5);
        check("srst_rst_cyc", 32'(rst_cycles), 32'd2);
        check("srst_status", status, 32'h0);
        check("srst_irq", 32'(irq_cnt), 32'd0);
        start_frame(4, 2);
        wait_eof(100);
        check_frame(4, 2);
        finish_done();
        check("restart_status", status, 32'h2);

        // Second start during STREAM is ignored but flagged.
        toggle_en = 1'b1;
        start_frame(4, 2);
        for (int i = 0; i < 100 && beat_q.size() < 1; i++) begin
            @(negedge clk); #1;
        end
        pulse_ctrl(0);
        wait_eof(200);
        toggle_en = 1'b0;
        #2 bus.pix_ready = 1'b1;
        check("ign_flag", 32'(status[4]), 32'd1);
        check_frame(4, 2);
        finish_done();
        check("ign_status", status, 32'h12);
        check("ign_irq", 32'(irq_cnt), 32'd1);

        // Single-pixel frame; accepted start clears the ignored flag.
        start_frame(1, 1);
        wait_eof(100);
        check_frame(1, 1);
        finish_done();
        check("one_status", status, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
